// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//
// Contents:
//   RF_WIDTH_DEF / RF_DEPTH_DEF  default word width and register count
//   RF_AW_DEF                    index width for the default depth
//   rf_idx_t / rf_word_t         index and word types for the default configuration
//
// Parameterised instances derive their own index and word widths from WIDTH/DEPTH.
// These typedefs describe the default 16x8 build.
package regfile_pkg;

  localparam int unsigned RF_WIDTH_DEF = 16;
  localparam int unsigned RF_DEPTH_DEF = 8;
  localparam int unsigned RF_AW_DEF    = $clog2(RF_DEPTH_DEF);

  typedef logic [RF_AW_DEF-1:0]    rf_idx_t;
  typedef logic [RF_WIDTH_DEF-1:0] rf_word_t;

endpackage

// File: rtl/rf_cell.sv
// Single register-file entry: a WIDTH-bit register with load enable and
// asynchronous active-low clear.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low clear (register goes to 0)
//   load   capture d on the next rising edge
//   d      data to capture
//   q      stored value
module rf_cell #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports and a
// per-register busy scoreboard for read-after-write hazard detection.
//
// Parameters:
//   WIDTH  data width of each register
//   DEPTH  number of registers (power of two, at least 2)
//   AW     index width, derived from DEPTH
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   write, writenum, data_in writeback port (one-cycle latency into storage)
//   readnum_a/b, data_out_a/b  combinational read ports A and B
//   issue, issuenum          reserve a destination register (sets its busy bit)
//   busy                     scoreboard vector, bit i = register i has a pending write
//   use_a, use_b             operand A/B actually needed this cycle
//   hazard                   a needed operand is busy
//
// Build option: define REGFILE_SB_BYPASS_EN to forward a same-cycle write to
// the read ports and let that in-flight write satisfy the hazard check.
// Without it, reads return stored contents and hazard uses busy alone.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = RF_WIDTH_DEF,
  parameter  int unsigned DEPTH = RF_DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             issue,
  input  logic [AW-1:0]    issuenum,
  output logic [DEPTH-1:0] busy,
  output logic             hazard,
  input  logic             use_a,
  input  logic             use_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] iss_dec;
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_eff;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // One-hot decode of the write and issue indices. DEPTH is a power of two,
  // so every AW-bit index selects a real register.
  always_comb begin
    wr_dec            = '0;
    iss_dec           = '0;
    wr_dec[writenum]  = write;
    iss_dec[issuenum] = issue;
  end

  // Storage
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    rf_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (wr_dec[i]),
      .d     (data_in),
      .q     (regs[i])
    );
  end

  // Scoreboard: a completing write clears, a new reservation sets, and the
  // reservation wins when both hit the same register on one edge.
  always_comb begin
    busy_d = (busy_q & ~wr_dec) | iss_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  // Read ports
  assign stored_a = regs[readnum_a];
  assign stored_b = regs[readnum_b];

`ifdef REGFILE_SB_BYPASS_EN
  // The writeback in flight this cycle supplies the operand directly, so its
  // target no longer counts as a hazard.
  always_comb begin
    data_out_a = (write && (writenum == readnum_a)) ? data_in : stored_a;
    data_out_b = (write && (writenum == readnum_b)) ? data_in : stored_b;
    busy_eff   = busy_q & ~wr_dec;
  end
`else
  always_comb begin
    data_out_a = stored_a;
    data_out_b = stored_b;
    busy_eff   = busy_q;
  end
`endif

  assign hazard = (use_a & busy_eff[readnum_a]) | (use_b & busy_eff[readnum_b]);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected values into a
// queue, a monitor pops and compares them on the falling clock edge.
module tb_regfile_sb;
  import regfile_pkg::*;

  typedef enum int {KA, KB, KBUSY, KHAZ, KBA, KBB, KBBUSY} chk_e;
  typedef struct {
    chk_e        kind;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n;

  // Default 16x8 instance
  logic     write, issue, use_a, use_b, hazard;
  rf_idx_t  writenum, readnum_a, readnum_b, issuenum;
  rf_word_t data_in, data_out_a, data_out_b;
  logic [7:0] busy;

  // 32x16 instance
  logic        b_write, b_issue, b_use_a, b_use_b, b_hazard;
  logic [3:0]  b_writenum, b_readnum_a, b_readnum_b, b_issuenum;
  logic [31:0] b_data_in, b_data_out_a, b_data_out_b;
  logic [15:0] b_busy;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .writenum   (writenum),
    .data_in    (data_in),
    .readnum_a  (readnum_a),
    .readnum_b  (readnum_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .issue      (issue),
    .issuenum   (issuenum),
    .busy       (busy),
    .hazard     (hazard),
    .use_a      (use_a),
    .use_b      (use_b)
  );

  regfile_sb #(
    .WIDTH (32),
    .DEPTH (16)
  ) u_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (b_write),
    .writenum   (b_writenum),
    .data_in    (b_data_in),
    .readnum_a  (b_readnum_a),
    .readnum_b  (b_readnum_b),
    .data_out_a (b_data_out_a),
    .data_out_b (b_data_out_b),
    .issue      (b_issue),
    .issuenum   (b_issuenum),
    .busy       (b_busy),
    .hazard     (b_hazard),
    .use_a      (b_use_a),
    .use_b      (b_use_b)
  );

  task automatic chk(input chk_e k, input logic [31:0] v, input string nm);
    sb_q.push_back('{kind: k, val: v, name: nm});
  endtask

  // Advance to just after the next rising edge and drop single-cycle strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    write   = 1'b0;
    issue   = 1'b0;
    b_write = 1'b0;
    b_issue = 1'b0;
  endtask

  // Monitor
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        case (c.kind)
          KA:      act = 32'(data_out_a);
          KB:      act = 32'(data_out_b);
          KBUSY:   act = 32'(busy);
          KHAZ:    act = 32'(hazard);
          KBA:     act = b_data_out_a;
          KBB:     act = b_data_out_b;
          default: act = 32'(b_busy);
        endcase
        n_tests++;
        if (act !== c.val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    write = 1'b0; issue = 1'b0; use_a = 1'b0; use_b = 1'b0;
    writenum = '0; readnum_a = '0; readnum_b = '0; issuenum = '0; data_in = '0;
    b_write = 1'b0; b_issue = 1'b0; b_use_a = 1'b0; b_use_b = 1'b0;
    b_writenum = '0; b_readnum_a = '0; b_readnum_b = '0; b_issuenum = '0; b_data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Build up state, then reset asynchronously mid-run
    cyc(); write = 1; writenum = 3; data_in = 16'h1111; issue = 1; issuenum = 1;
    cyc(); rst_n = 0; readnum_a = 3; readnum_b = 1; use_a = 1; use_b = 1;
    chk(KA, 32'h0, "rst_data_a"); chk(KB, 32'h0, "rst_data_b");
    chk(KBUSY, 32'h0, "rst_busy"); chk(KHAZ, 32'h0, "rst_hazard");
    chk(KBBUSY, 32'h0, "rst_big_busy"); chk(KBA, 32'h0, "rst_big_a");
    cyc(); rst_n = 1; use_a = 0; use_b = 0;

    // Write then read on the following cycle
    cyc(); write = 1; writenum = 3; data_in = 16'hBEEF;
    cyc(); readnum_a = 3; readnum_b = 0;
    chk(KA, 32'hBEEF, "write_r3_a"); chk(KB, 32'h0000, "read_r0_b");

    // Both ports on the same register; write to a non-busy register
    cyc(); write = 1; writenum = 5; data_in = 16'h1234;
    cyc(); readnum_a = 5; readnum_b = 5;
    chk(KA, 32'h1234, "dual_r5_a"); chk(KB, 32'h1234, "dual_r5_b");
    chk(KBUSY, 32'h0, "nonbusy_write_busy");

    // Reservation and hazard
    cyc(); issue = 1; issuenum = 2;
    cyc(); readnum_a = 2; use_a = 1;
    chk(KBUSY, 32'h04, "issue2_busy"); chk(KHAZ, 32'h1, "issue2_hazard");
    cyc(); use_a = 0;
    chk(KHAZ, 32'h0, "unused_a_hazard"); chk(KBUSY, 32'h04, "issue2_busy_hold");
    cyc(); write = 1; writenum = 2; data_in = 16'h00AA; use_a = 1;
`ifdef REGFILE_SB_BYPASS_EN
    chk(KHAZ, 32'h0, "wb_cycle_hazard"); chk(KA, 32'h00AA, "wb_cycle_fwd_a");
`else
    chk(KHAZ, 32'h1, "wb_cycle_hazard"); chk(KA, 32'h0000, "wb_cycle_old_a");
`endif
    cyc();
    chk(KBUSY, 32'h0, "wb2_busy"); chk(KHAZ, 32'h0, "wb2_hazard"); chk(KA, 32'h00AA, "wb2_a");

    // Set and clear on the same edge; then a repeated issue and one clearing write
    cyc(); use_a = 0; issue = 1; issuenum = 6; write = 1; writenum = 6; data_in = 16'h5555;
    cyc(); readnum_a = 6; issue = 1; issuenum = 6;
    chk(KA, 32'h5555, "setclr_r6"); chk(KBUSY, 32'h40, "setclr_busy");
    cyc(); write = 1; writenum = 6; data_in = 16'h6666;
    chk(KBUSY, 32'h40, "reissue_busy");
    cyc();
    chk(KBUSY, 32'h0, "reissue_clr_busy"); chk(KA, 32'h6666, "reissue_r6");

    // Same-cycle write to a reserved register being read
    cyc(); write = 1; writenum = 4; data_in = 16'h1111;
    cyc(); issue = 1; issuenum = 4;
    cyc(); write = 1; writenum = 4; data_in = 16'hCAFE; readnum_a = 4; use_a = 1;
    readnum_b = 0; use_b = 1;
    chk(KBUSY, 32'h10, "byp_busy");
`ifdef REGFILE_SB_BYPASS_EN
    chk(KA, 32'hCAFE, "byp_data_a"); chk(KHAZ, 32'h0, "byp_hazard");
`else
    chk(KA, 32'h1111, "nobyp_data_a"); chk(KHAZ, 32'h1, "nobyp_hazard");
`endif
    cyc();
    chk(KA, 32'hCAFE, "byp_after_a"); chk(KBUSY, 32'h0, "byp_after_busy");
    chk(KHAZ, 32'h0, "byp_after_hazard");
    use_a = 0; use_b = 0;

    // 32x16 sweep
    for (int i = 0; i < 16; i++) begin
      cyc(); b_write = 1; b_writenum = 4'(i); b_data_in = i * 32'h01010101;
    end
    for (int i = 0; i < 16; i++) begin
      cyc(); b_readnum_a = 4'(i); b_readnum_b = 4'(15 - i);
      chk(KBA, i * 32'h01010101, $sformatf("big_a_r%0d", i));
      chk(KBB, (15 - i) * 32'h01010101, $sformatf("big_b_r%0d", 15 - i));
    end
    chk(KBBUSY, 32'h0, "big_busy");

    cyc();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
      n_fail += sb_q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
